clk_rst_sequencer: RTL and testbench

Synthesizable reset sequencer. It owns the reset outputs of NR_OF_DOMAINS_P downstream domains and drives each with its own polarity (active-low or active-high, per the team's reset_active_t encoding). After system reset or a software request, it asserts all domain resets together. It holds them for a programmable number of cycles, then releases them one at a time in index order with programmable spacing. It sits between the top-level reset and the per-domain reset inputs of the datapath blocks.

---
 rtl/clk_rst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_clk_rst_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_sequencer.sv
// Reset sequencer: asserts all domain resets, holds them, then releases them one by one.
// Optional build macro CLK_RST_SEQ_REQ_RESTART_EN: a request edge during HOLD/RELEASE restarts the sequence.
module clk_rst_sequencer #(
  parameter int                         NR_OF_DOMAINS_P    = 4,
  parameter int                         COUNTER_WIDTH_P    = 8,
  parameter logic [NR_OF_DOMAINS_P-1:0] ACTIVE_HIGH_MASK_P = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COUNTER_WIDTH_P-1:0] cr_hold_cycles,
  input  logic [COUNTER_WIDTH_P-1:0] cr_stagger_cycles,
  input  logic                       sw_reset_req,
  output logic                       sw_reset_ack,
  output logic [NR_OF_DOMAINS_P-1:0] domain_rst,
  output logic [NR_OF_DOMAINS_P-1:0] domain_in_reset,
  output logic                       sequencer_busy,
  output logic                       sequence_done
);

  localparam int IDX_W = (NR_OF_DOMAINS_P > 1) ? $clog2(NR_OF_DOMAINS_P) : 1;
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NR_OF_DOMAINS_P - 1);
  localparam logic [IDX_W-1:0]           IDX_ONE  = IDX_W'(1);
  localparam logic [COUNTER_WIDTH_P-1:0] CNT_ONE  = COUNTER_WIDTH_P'(1);
  localparam logic [NR_OF_DOMAINS_P-1:0] ALL_IN_RESET = '1;

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [COUNTER_WIDTH_P-1:0] hold_cnt_q, hold_cnt_d;
  logic [COUNTER_WIDTH_P-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [COUNTER_WIDTH_P-1:0] h_lat_q, h_lat_d;
  logic [COUNTER_WIDTH_P-1:0] s_lat_q, s_lat_d;
  logic                       req_flag_q, req_flag_d;
  logic                       por_q, por_d;
  logic [NR_OF_DOMAINS_P-1:0] in_reset_q, in_reset_d;
  logic [NR_OF_DOMAINS_P-1:0] rst_out_q;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       ack_q, ack_d;
  logic                       start_seq;

  // Last hold count value; a hold length of 0 behaves as 1.
  function automatic logic [COUNTER_WIDTH_P-1:0] hold_last(input logic [COUNTER_WIDTH_P-1:0] h);
    return (h == '0) ? '0 : (h - CNT_ONE);
  endfunction

  function automatic logic [NR_OF_DOMAINS_P-1:0] to_phys(input logic [NR_OF_DOMAINS_P-1:0] v);
    return ~(v ^ ACTIVE_HIGH_MASK_P);
  endfunction

`ifdef CLK_RST_SEQ_REQ_RESTART_EN
  logic req_q;
  logic req_rise;

  always_ff @(posedge clk) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= sw_reset_req;
  end

  assign req_rise = sw_reset_req & ~req_q;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    h_lat_d    = h_lat_q;
    s_lat_d    = s_lat_q;
    req_flag_d = req_flag_q;
    por_d      = por_q;
    in_reset_d = in_reset_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_d      = 1'b0;
    start_seq  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        in_reset_d = '0;
        start_seq  = sw_reset_req;
      end
      HOLD: begin
        if (hold_cnt_q == hold_last(h_lat_q)) begin
          state_d    = RELEASE;
          hold_cnt_d = '0;
          idx_d      = '0;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      RELEASE: begin
        // Release on a zero wait count, then reload the stagger gap before the next domain.
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CNT_ONE;
        end else begin
          in_reset_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + IDX_ONE;
            wait_cnt_d = s_lat_q;
          end
        end
      end
      DONE: begin
        done_d     = 1'b1;
        ack_d      = req_flag_q & ~por_q;
        req_flag_d = 1'b0;
        por_d      = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef CLK_RST_SEQ_REQ_RESTART_EN
    if (req_rise && (state_q == HOLD || state_q == RELEASE)) start_seq = 1'b1;
`endif

    if (start_seq) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      wait_cnt_d = '0;
      idx_d      = '0;
      h_lat_d    = cr_hold_cycles;
      s_lat_d    = cr_stagger_cycles;
      req_flag_d = 1'b1;
      por_d      = 1'b0;
      in_reset_d = ALL_IN_RESET;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      h_lat_q    <= cr_hold_cycles;
      s_lat_q    <= cr_stagger_cycles;
      req_flag_q <= 1'b0;
      por_q      <= 1'b1;
      in_reset_q <= ALL_IN_RESET;
      rst_out_q  <= to_phys(ALL_IN_RESET);
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      h_lat_q    <= h_lat_d;
      s_lat_q    <= s_lat_d;
      req_flag_q <= req_flag_d;
      por_q      <= por_d;
      in_reset_q <= in_reset_d;
      rst_out_q  <= to_phys(in_reset_d);
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
    end
  end

  assign domain_in_reset = in_reset_q;
  assign domain_rst      = rst_out_q;
  assign sequencer_busy  = busy_q;
  assign sequence_done   = done_q;
  assign sw_reset_ack    = ack_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: timing model from release-time arithmetic plus literal timing checks.
module tb_clk_rst_sequencer;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam logic [N-1:0] MASK = 4'b0101;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cr_hold = 8'd3;
  logic [CW-1:0] cr_stag = 8'd2;
  logic          sw_reset_req = 1'b0;
  logic          sw_reset_ack;
  logic [N-1:0]  domain_rst;
  logic [N-1:0]  domain_in_reset;
  logic          sequencer_busy;
  logic          sequence_done;

  clk_rst_sequencer #(
    .NR_OF_DOMAINS_P    (N),
    .COUNTER_WIDTH_P    (CW),
    .ACTIVE_HIGH_MASK_P (MASK)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cr_hold_cycles    (cr_hold),
    .cr_stagger_cycles (cr_stag),
    .sw_reset_req      (sw_reset_req),
    .sw_reset_ack      (sw_reset_ack),
    .domain_rst        (domain_rst),
    .domain_in_reset   (domain_in_reset),
    .sequencer_busy    (sequencer_busy),
    .sequence_done     (sequence_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;

  // Model state: a sequence is described by its first HOLD edge, hold length and stagger.
  bit           m_valid = 1'b0;
  bit           m_in_seq = 1'b0;
  int           m_start = 0;
  int           m_hl = 1;
  int           m_sl = 0;
  bit           m_req_flag = 1'b0;
  bit           m_req_prev = 1'b0;
  logic [N-1:0] exp_in = '1;
  logic         exp_busy = 1'b1;
  logic         exp_done = 1'b0;
  logic         exp_ack = 1'b0;

  task automatic m_begin(input int n);
    m_in_seq   = 1'b1;
    m_start    = n + 1;
    m_hl       = (cr_hold == 0) ? 1 : int'(cr_hold);
    m_sl       = int'(cr_stag);
    m_req_flag = 1'b1;
    exp_in     = '1;
    exp_busy   = 1'b1;
  endtask

  initial begin
    forever begin
      int rel_end;
      bit restart_hit;
      @(posedge clk);
      rel_end     = m_start + m_hl + (N - 1) * (m_sl + 1);
      restart_hit = 1'b0;
`ifdef CLK_RST_SEQ_REQ_RESTART_EN
      restart_hit = sw_reset_req && !m_req_prev && (cyc <= rel_end);
      m_req_prev  = rst ? 1'b0 : sw_reset_req;
`endif
      exp_done = 1'b0;
      exp_ack  = 1'b0;
      if (rst) begin
        exp_in     = '1;
        exp_busy   = 1'b1;
        m_in_seq   = 1'b1;
        m_start    = cyc + 1;
        m_hl       = (cr_hold == 0) ? 1 : int'(cr_hold);
        m_sl       = int'(cr_stag);
        m_req_flag = 1'b0;
      end else if (m_in_seq && restart_hit) begin
        m_begin(cyc);
      end else if (m_in_seq && cyc == rel_end + 1) begin
        exp_done   = 1'b1;
        exp_ack    = m_req_flag;
        m_req_flag = 1'b0;
        m_in_seq   = 1'b0;
        exp_in     = '0;
        exp_busy   = 1'b1;
      end else if (m_in_seq) begin
        for (int k = 0; k < N; k++) exp_in[k] = (cyc < m_start + m_hl + k * (m_sl + 1));
        exp_busy = 1'b1;
      end else if (sw_reset_req) begin
        m_begin(cyc);
      end else begin
        exp_in   = '0;
        exp_busy = 1'b0;
      end
      m_valid = 1'b1;
      cyc = cyc + 1;
    end
  end

  initial begin
    forever begin
      logic [N-1:0] exp_rst;
      @(negedge clk);
      if (sw_reset_ack) ack_cnt++;
      if (m_valid) begin
        for (int i = 0; i < N; i++) exp_rst[i] = MASK[i] ? exp_in[i] : ~exp_in[i];
        vectors++;
        if (domain_in_reset !== exp_in || domain_rst !== exp_rst || sequencer_busy !== exp_busy ||
            sequence_done !== exp_done || sw_reset_ack !== exp_ack) begin
          miscompares++;
          $display("FAIL cycle%0d outputs: got in=%b rst=%b busy=%b done=%b ack=%b, want in=%b rst=%b busy=%b done=%b ack=%b",
                   cyc, domain_in_reset, domain_rst, sequencer_busy, sequence_done, sw_reset_ack,
                   exp_in, exp_rst, exp_busy, exp_done, exp_ack);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // sel 0..N-1: domain sel leaves reset; N: sequence_done; N+1: sw_reset_ack.
  task automatic wait_for(input int sel, input int bound, output int edge_n);
    edge_n = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((sel < N && domain_in_reset[sel] == 1'b0) || (sel == N && sequence_done) ||
          (sel == N + 1 && sw_reset_ack)) begin
        edge_n = cyc - 1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL wait sel%0d: got timeout after %0d cycles, want event", sel, bound);
  endtask

  initial begin
    int e0, t, e, a0;
    // power-on sequence
    repeat (5) @(negedge clk);
    chk("por_domain_rst", int'(domain_rst), 5);
    chk("por_in_reset", int'(domain_in_reset), 15);
    chk("por_busy", int'(sequencer_busy), 1);
    rst = 1'b0;
    e0 = cyc;
    wait_for(0, 30, e); chk("por_dom0", e - e0, 3);
    wait_for(1, 30, e); chk("por_dom1", e - e0, 6);
    wait_for(2, 30, e); chk("por_dom2", e - e0, 9);
    wait_for(3, 30, e); chk("por_dom3", e - e0, 12);
    wait_for(N, 30, e); chk("por_done", e - e0, 13);
    @(negedge clk);
    chk("por_busy_low", int'(sequencer_busy), 0);
    chk("por_no_ack", ack_cnt, 0);

    // software request, H=0 S=0
    cr_hold = 8'd0; cr_stag = 8'd0; sw_reset_req = 1'b1;
    t = cyc;
    @(negedge clk);
    chk("sw_all_in_reset", int'(domain_in_reset), 15);
    wait_for(0, 30, e); chk("sw_dom0", e - t, 2);
    wait_for(3, 30, e); chk("sw_dom3", e - t, 5);
    wait_for(N + 1, 30, e); chk("sw_ack", e - t, 6);
    sw_reset_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("sw_idle_busy", int'(sequencer_busy), 0);
    chk("sw_idle_in_reset", int'(domain_in_reset), 0);

    // held request: back-to-back sequences
    sw_reset_req = 1'b1;
    t = cyc;
    wait_for(N + 1, 30, e); chk("held_ack1", e - t, 6);
    wait_for(N + 1, 30, e); chk("held_ack2", e - t, 13);
    sw_reset_req = 1'b0;
    repeat (4) @(negedge clk);

    // config change during HOLD
    cr_hold = 8'd10; cr_stag = 8'd1; sw_reset_req = 1'b1;
    t = cyc;
    @(negedge clk);
    cr_hold = 8'd2;
    wait_for(0, 40, e); chk("cfg_dom0", e - t, 11);
    wait_for(N + 1, 40, e); chk("cfg_ack", e - t, 18);
    sw_reset_req = 1'b0;
    repeat (3) @(negedge clk);

    // reset during RELEASE
    cr_hold = 8'd2; cr_stag = 8'd3; sw_reset_req = 1'b1;
    t = cyc;
    wait_for(1, 40, e); chk("mid_dom1", e - t, 7);
    rst = 1'b1; sw_reset_req = 1'b0; cr_hold = 8'd4; cr_stag = 8'd0;
    a0 = ack_cnt;
    @(negedge clk);
    chk("mid_all_in_reset", int'(domain_in_reset), 15);
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc;
    wait_for(0, 40, e); chk("mid_replay_dom0", e - e0, 4);
    wait_for(N, 40, e); chk("mid_replay_done", e - e0, 8);
    @(negedge clk);
    chk("mid_no_ack", ack_cnt - a0, 0);

    // request edge during RELEASE of the power-on sequence
    rst = 1'b1; cr_hold = 8'd1; cr_stag = 8'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = cyc;
    wait_for(1, 40, e); chk("rs_dom1", e - e0, 4);
    sw_reset_req = 1'b1;
    a0 = ack_cnt;
    wait_for(N + 1, 80, e);
`ifdef CLK_RST_SEQ_REQ_RESTART_EN
    chk("rs_ack", e - e0, 17);
`else
    chk("rs_ack", e - e0, 24);
`endif
    sw_reset_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rs_one_ack", ack_cnt - a0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1);
  end

endmodule
